// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-RAM port arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 32;

   // Which requester owns the response that is in flight this cycle.
   typedef enum logic [1:0] {
      R_NONE = 2'd0,
      R_I    = 2'd1,
      R_D    = 2'd2
   } rsp_owner_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_grant.sv
// Grant logic for the unified-RAM arbiter: fixed priority to load/store.
// Optional build macro MEM_ARB_STARVE_GUARD_EN adds a counter that forces an
// instruction-fetch grant after STARVE_MAX consecutive D grants with I waiting.
module mem_arb_grant
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
`ifdef MEM_ARB_STARVE_GUARD_EN
   input  logic clk,
`endif
   input  logic rst,
   input  logic i_valid,
   input  logic d_valid,
   output logic gnt_i,
   output logic gnt_d
);

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt_q;
   logic [CNT_W-1:0] starve_cnt_d;
   logic             force_i;

   // I has waited through STARVE_MAX D grants: it wins this cycle.
   always_comb begin
      force_i = i_valid && (starve_cnt_q == CNT_W'(STARVE_MAX));
      gnt_d   = !rst && d_valid && !force_i;
      gnt_i   = !rst && i_valid && (!d_valid || force_i);
   end

   // Count D grants taken while I is waiting; any I grant or idle I clears it.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!i_valid || gnt_i) begin
         starve_cnt_d = '0;
      end else if (gnt_d) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   // Pure D priority; ready is held low while in reset.
   always_comb begin
      gnt_d = !rst && d_valid;
      gnt_i = !rst && i_valid && !d_valid;
   end
`endif

endmodule : mem_arb_grant

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch I, load/store D) in front of a single-port RAM.
// One access per cycle, response registered one cycle after accept.
// Build macro MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              i_ready,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_rsp_valid,
   output logic [DATA_W-1:0] i_rsp_rdata,
   input  logic              d_valid,
   output logic              d_ready,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_rsp_valid,
   output logic [DATA_W-1:0] d_rsp_rdata,
   output logic              ram_w_en,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic       gnt_i;
   logic       gnt_d;
   rsp_owner_e owner_q;
   rsp_owner_e owner_d;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   mem_arb_grant #(
      .STARVE_MAX (STARVE_MAX)
   ) u_grant (
`ifdef MEM_ARB_STARVE_GUARD_EN
      .clk     (clk),
`endif
      .rst     (rst),
      .i_valid (i_valid),
      .d_valid (d_valid),
      .gnt_i   (gnt_i),
      .gnt_d   (gnt_d)
   );

   // Steer the granted request onto the RAM port; idle port parks at address 0.
   always_comb begin
      i_ready     = gnt_i;
      d_ready     = gnt_d;
      ram_w_en    = gnt_d && d_we;
      ram_wdata   = d_wdata;
      ram_address = '0;
      if (gnt_d) begin
         ram_address = d_addr;
      end else if (gnt_i) begin
         ram_address = i_addr;
      end
   end

   // Next response owner and data; a store acknowledges with zero data.
   always_comb begin
      owner_d = R_NONE;
      if (gnt_d) begin
         owner_d = R_D;
      end else if (gnt_i) begin
         owner_d = R_I;
      end
      rdata_d = (gnt_d && d_we) ? '0 : ram_rdata;
   end

   // Response stage: owner is control (reset), read data is datapath (no reset).
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= R_NONE;
      end else begin
         owner_q <= owner_d;
      end
      rdata_q <= rdata_d;
   end

   // Response outputs; asserting rst drops an in-flight response immediately.
   always_comb begin
      i_rsp_valid = (owner_q == R_I) && !rst;
      d_rsp_valid = (owner_q == R_D) && !rst;
      i_rsp_rdata = (owner_q == R_I) ? rdata_q : '0;
      d_rsp_rdata = (owner_q == R_D) ? rdata_q : '0;
   end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 4096x32 RAM.
module tb_mem_port_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic          i_valid;
   logic          i_ready;
   logic [AW-1:0] i_addr;
   logic          i_rsp_valid;
   logic [DW-1:0] i_rsp_rdata;
   logic          d_valid;
   logic          d_ready;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_rsp_valid;
   logic [DW-1:0] d_rsp_rdata;
   logic          ram_w_en;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int vectors;
   int miscompares;

   mem_port_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .STARVE_MAX (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .i_ready     (i_ready),
      .i_addr      (i_addr),
      .i_rsp_valid (i_rsp_valid),
      .i_rsp_rdata (i_rsp_rdata),
      .d_valid     (d_valid),
      .d_ready     (d_ready),
      .d_we        (d_we),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_rsp_valid (d_rsp_valid),
      .d_rsp_rdata (d_rsp_rdata),
      .ram_w_en    (ram_w_en),
      .ram_address (ram_address),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural RAM: combinational read, write on posedge.
   assign ram_rdata = mem[ram_address];
   always @(posedge clk) begin
      if (ram_w_en) mem[ram_address] <= ram_wdata;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_i;
      vectors     = 0;
      miscompares = 0;
      for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
      mem[12'h010] = 32'hDEADBEEF;
      mem[12'h123] = 32'hA5A50123;

      // 1: reset held 3 cycles with both requesters valid
      rst     = 1'b1;
      i_valid = 1'b1;
      i_addr  = 12'h010;
      d_valid = 1'b1;
      d_we    = 1'b0;
      d_addr  = 12'h123;
      d_wdata = 32'h0;
      for (int k = 0; k < 3; k++) begin
         tick(); #2;
         chk("rst_i_ready",   {31'b0, i_ready},     32'd0);
         chk("rst_d_ready",   {31'b0, d_ready},     32'd0);
         chk("rst_w_en",      {31'b0, ram_w_en},    32'd0);
         chk("rst_i_rsp_vld", {31'b0, i_rsp_valid}, 32'd0);
         chk("rst_d_rsp_vld", {31'b0, d_rsp_valid}, 32'd0);
         chk("rst_d_rdata",   d_rsp_rdata,          32'd0);
      end
      rst = 1'b0;
      #1;
      chk("rel_d_ready", {31'b0, d_ready}, 32'd1);
      chk("rel_i_ready", {31'b0, i_ready}, 32'd0);
      chk("rel_addr",    {20'b0, ram_address}, 32'h123);

      // 2: single fetch after the D load completes
      tick(); d_valid = 1'b0; #2;
      chk("t2_d_rsp_vld", {31'b0, d_rsp_valid}, 32'd1);
      chk("t2_d_rdata",   d_rsp_rdata,          32'hA5A50123);
      chk("t2_i_ready",   {31'b0, i_ready},     32'd1);
      chk("t2_addr",      {20'b0, ram_address}, 32'h010);
      tick(); i_valid = 1'b0; #2;
      chk("t2_i_rsp_vld", {31'b0, i_rsp_valid}, 32'd1);
      chk("t2_i_rdata",   i_rsp_rdata,          32'hDEADBEEF);
      chk("t2_d_rsp_idle",{31'b0, d_rsp_valid}, 32'd0);
      chk("t2_i_ready_lo",{31'b0, i_ready},     32'd0);

      // 3: store then load to 0x7FF
      d_valid = 1'b1; d_we = 1'b1; d_addr = 12'h7FF; d_wdata = 32'h12345678;
      #1;
      chk("t3_st_ready", {31'b0, d_ready},     32'd1);
      chk("t3_st_w_en",  {31'b0, ram_w_en},    32'd1);
      chk("t3_st_addr",  {20'b0, ram_address}, 32'h7FF);
      tick(); d_we = 1'b0; #2;
      chk("t3_ld_w_en",  {31'b0, ram_w_en},    32'd0);
      chk("t3_ack_vld",  {31'b0, d_rsp_valid}, 32'd1);
      chk("t3_ack_data", d_rsp_rdata,          32'd0);
      tick(); d_valid = 1'b0; #2;
      chk("t3_ld_vld",   {31'b0, d_rsp_valid}, 32'd1);
      chk("t3_ld_data",  d_rsp_rdata,          32'h12345678);

      // 4: simultaneous requests for one cycle
      tick();
      i_valid = 1'b1; i_addr = 12'h010;
      d_valid = 1'b1; d_we = 1'b0; d_addr = 12'h7FF;
      #2;
      chk("t4_d_first",  {31'b0, d_ready}, 32'd1);
      chk("t4_i_wait",   {31'b0, i_ready}, 32'd0);
      tick(); d_valid = 1'b0; #2;
      chk("t4_i_second", {31'b0, i_ready},     32'd1);
      chk("t4_d_rsp",    {31'b0, d_rsp_valid}, 32'd1);
      chk("t4_d_rdata",  d_rsp_rdata,          32'h12345678);
      chk("t4_i_rsp_no", {31'b0, i_rsp_valid}, 32'd0);
      tick(); i_valid = 1'b0; #2;
      chk("t4_i_rsp",    {31'b0, i_rsp_valid}, 32'd1);
      chk("t4_i_rdata",  i_rsp_rdata,          32'hDEADBEEF);
      chk("t4_d_rsp_no", {31'b0, d_rsp_valid}, 32'd0);

      // 5: both held for 10 cycles
      tick();
      i_valid = 1'b1; i_addr = 12'h010;
      d_valid = 1'b1; d_we = 1'b0; d_addr = 12'h123;
      for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
         exp_i = (k == 4) || (k == 9);
`else
         exp_i = 1'b0;
`endif
         #2;
         chk($sformatf("t5_i_ready_%0d", k), {31'b0, i_ready}, {31'b0, exp_i});
         chk($sformatf("t5_d_ready_%0d", k), {31'b0, d_ready}, {31'b0, ~exp_i});
         tick();
      end
      i_valid = 1'b0; d_valid = 1'b0; #2;
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk("t5_last_i_rsp", {31'b0, i_rsp_valid}, 32'd1);
      chk("t5_last_rdata", i_rsp_rdata,          32'hDEADBEEF);
`else
      chk("t5_last_d_rsp", {31'b0, d_rsp_valid}, 32'd1);
      chk("t5_last_rdata", d_rsp_rdata,          32'hA5A50123);
`endif

      // 6: reset while a load response is in flight
      tick();
      d_valid = 1'b1; d_we = 1'b0; d_addr = 12'h123;
      #2;
      chk("t6_acc", {31'b0, d_ready}, 32'd1);
      tick(); d_valid = 1'b0; rst = 1'b1; #2;
      chk("t6_drop_vld",  {31'b0, d_rsp_valid}, 32'd0);
      tick(); rst = 1'b0; #2;
      chk("t6_post_vld",  {31'b0, d_rsp_valid}, 32'd0);
      chk("t6_post_data", d_rsp_rdata,          32'd0);
      d_valid = 1'b1; d_addr = 12'h7FF;
      #1;
      chk("t6_new_acc", {31'b0, d_ready}, 32'd1);
      tick(); d_valid = 1'b0; #2;
      chk("t6_new_vld",  {31'b0, d_rsp_valid}, 32'd1);
      chk("t6_new_data", d_rsp_rdata,          32'h12345678);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_mem_port_arbiter
